// File: rtl/flop_resp_checker_if.sv
// Bundle between the flop-stack stimulus/observation side and the response checker.
// The master drives stimulus and observed DUT outputs; the slave (checker) reports verdicts.
interface flop_resp_checker_if #(
    parameter int CNT_W = 8
);
    logic             i_srst;
    logic             i_w;
    logic             i_z;
    logic             i_y;
    logic             i_x;
    logic             o_checking;
    logic             o_mismatch;
    logic [2:0]       o_mis_vec;
    logic             o_fail;
    logic [CNT_W-1:0] o_err_cnt;

    modport master (
        output i_srst, i_w, i_z, i_y, i_x,
        input  o_checking, o_mismatch, o_mis_vec, o_fail, o_err_cnt
    );

    modport slave (
        input  i_srst, i_w, i_z, i_y, i_x,
        output o_checking, o_mismatch, o_mis_vec, o_fail, o_err_cnt
    );
endinterface

// File: rtl/flop_resp_checker.sv
// Cycle-by-cycle checker for the registered z/y/x flop test stack: keeps its own
// reference flops, waits out a warm-up window, then flags and counts mismatches.
module flop_resp_checker #(
    parameter int CNT_W        = 8,
    parameter int WARMUP       = 2,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    flop_resp_checker_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_CHECK = 2'd2,
        S_FAIL  = 2'd3
    } state_t;

    localparam logic [3:0]       WARM_LOAD = 4'(WARMUP - 1);
    localparam logic [CNT_W-1:0] ERR_MAX   = {CNT_W{1'b1}};

    state_t           state_q, state_d;
    logic [3:0]       warm_cnt_q, warm_cnt_d;
    logic             x_exp_q, x_exp_d;
    logic             y_exp_q, y_exp_d;
    logic             z_exp_q, z_exp_d;
    logic             mismatch_q, mismatch_d;
    logic [2:0]       mis_vec_q, mis_vec_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [2:0]       mis;
    logic             mis_any;

    assign mis = {bus.i_z ^ z_exp_q, bus.i_y ^ y_exp_q, bus.i_x ^ x_exp_q};

    // case matching is exact, so an unknown observed bit falls into the mismatch arm
    always_comb begin
        case (mis)
            3'b000:  mis_any = 1'b0;
            default: mis_any = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        warm_cnt_d = warm_cnt_q;
        mismatch_d = 1'b0;
        mis_vec_d  = mis_vec_q;
        fail_d     = fail_q;
        err_cnt_d  = err_cnt_q;
        x_exp_d    = bus.i_srst ? 1'b0 : bus.i_w;
        y_exp_d    = ~bus.i_srst;
        z_exp_d    = bus.i_srst;
        case (state_q)
            S_IDLE: begin
                state_d    = S_WARM;
                warm_cnt_d = WARM_LOAD;
            end
            S_WARM: begin
                // a sync reset pulse restarts the quiet window, even on its final cycle
                if (bus.i_srst) begin
                    warm_cnt_d = WARM_LOAD;
                end else if (warm_cnt_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    warm_cnt_d = warm_cnt_q - 4'd1;
                end
            end
            S_CHECK: begin
                mismatch_d = mis_any;
                mis_vec_d  = mis;
                if (mis_any) begin
                    fail_d = 1'b1;
                    if (err_cnt_q != ERR_MAX) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (STOP_ON_FAIL) begin
                        state_d = S_FAIL;
                    end
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            state_q    <= S_IDLE;
            warm_cnt_q <= 4'd0;
            x_exp_q    <= 1'b0;
            y_exp_q    <= 1'b0;
            z_exp_q    <= 1'b0;
            mismatch_q <= 1'b0;
            mis_vec_q  <= 3'b000;
            fail_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            warm_cnt_q <= warm_cnt_d;
            x_exp_q    <= x_exp_d;
            y_exp_q    <= y_exp_d;
            z_exp_q    <= z_exp_d;
            mismatch_q <= mismatch_d;
            mis_vec_q  <= mis_vec_d;
            fail_q     <= fail_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign bus.o_checking = (state_q == S_CHECK);
    assign bus.o_mismatch = mismatch_q;
    assign bus.o_mis_vec  = mis_vec_q;
    assign bus.o_fail     = fail_q;
    assign bus.o_err_cnt  = err_cnt_q;

endmodule
